// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the RV32I memory stage and a req/gnt + rvalid data bus.
// Checks alignment, builds byte enables and lane-replicated store data, extends load data.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  // state | meaning
  // IDLE  | ready for a request
  // ISSUE | mem_req held until mem_gnt
  // WAIT  | waiting for mem_rvalid or timeout
  // RESP  | one-cycle response pulse
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TC_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q;
  logic [2:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic          req_illegal;
  logic          req_misaligned;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [31:0]   ld_sh;
  logic [31:0]   ld_data;
  logic          issuing;

  always_comb begin
    if (req_we) req_illegal = (req_op >= 3'b011);
    else        req_illegal = (req_op == 3'b011) || (req_op == 3'b110) || (req_op == 3'b111);
    req_misaligned = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    case (op_q[1:0])
      2'b00:   begin st_be = 4'b0001 << addr_q[1:0]; st_wdata = {4{wdata_q[7:0]}};  end
      2'b01:   begin st_be = 4'b0011 << addr_q[1:0]; st_wdata = {2{wdata_q[15:0]}}; end
      default: begin st_be = 4'b1111;                st_wdata = wdata_q;             end
    endcase
  end

  // Load lane select: shift the addressed byte/half down to bit 0 before extending.
  assign ld_sh = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (op_q)
      3'b000:  ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b100:  ld_data = {24'd0, ld_sh[7:0]};
      3'b001:  ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b101:  ld_data = {16'd0, ld_sh[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal || req_misaligned) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid) begin
          state_d     = RESP;
          rsp_err_d   = mem_err;
          rsp_rdata_d = (mem_err || we_q) ? 32'd0 : ld_data;
        end else if (TO_EN && (cnt_q == TC_LAST)) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if ((state_q == IDLE) && req_valid) begin
        we_q    <= req_we;
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  assign issuing   = (state_q == ISSUE);
  assign req_ready = (state_q == IDLE) && !rst;
  assign mem_req   = issuing;
  assign mem_addr  = issuing ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_we    = issuing && we_q;
  assign mem_be    = issuing ? (we_q ? st_be : 4'b1111) : 4'b0000;
  assign mem_wdata = (issuing && we_q) ? st_wdata : 32'd0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the RV32I execute/memory stage and the word-addressed data memory bus.
- Accepts one load or store per handshake and checks alignment.
- Drives a req/gnt + rvalid memory protocol, generates byte enables and replicated store data, aligns and sign/zero-extends load data.
- Returns one response per accepted request; the core stalls on req_ready/rsp_valid.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT before aborting with error; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1=store, 0=load
- req_op  in  3  funct3: lb 000, lh 001, lw 010, lbu 100, lhu 101; sb 000, sh 001, sw 010
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits significant)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal op, bus error or timeout
- mem_req  out  1  bus request
- mem_gnt  in  1  bus accepted request this cycle
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  bus completion (loads and stores)
- mem_rdata  in  32  read word
- mem_err  in  1  bus error, qualified by mem_rvalid

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - state=IDLE; all mem_* outputs 0; rsp_valid=0, rsp_rdata=0, rsp_err=0; timeout counter 0.
  - req_ready = (state==IDLE) && !rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we, op, addr, wdata.
  - Illegal or misaligned request -> RESP with err=1; no bus activity.
  - Otherwise -> ISSUE.
- Illegal op: load op in {011,110,111}; store op >= 011.
- Misaligned: h-ops with addr[0]!=0; w-ops with addr[1:0]!=0.
- ISSUE:
  - mem_req=1; mem_addr/we/be/wdata held stable until mem_gnt.
  - mem_gnt=1 -> WAIT, with mem_req deasserted from the next cycle.
  - No timeout in ISSUE.
- WAIT:
  - Counter increments each cycle.
  - mem_rvalid -> RESP, capturing data and mem_err.
  - If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES without rvalid -> RESP with err=1.
  - rvalid and timeout in the same cycle: rvalid wins.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - Outputs are registered, valid only while rsp_valid=1, and 0 otherwise.
- mem_rvalid outside WAIT is ignored, including after reset mid-transaction.
- Minimum latency: accept at cycle N, ISSUE N+1 (gnt), WAIT N+2 (rvalid), rsp_valid at N+3. Back-to-back throughput is one request per 4 cycles.
- Store encoding, off = addr[1:0]:
  - sb: be = 0001<<off, wdata = {4{wdata[7:0]}}
  - sh: be = 0011<<off, wdata = {2{wdata[15:0]}}
  - sw: be = 1111, wdata as given
- Loads: mem_be=1111. sh = mem_rdata >> (8*off), then:
  - lb: sign-extend sh[7:0]
  - lbu: zero-extend sh[7:0]
  - lh: sign-extend sh[15:0]
  - lhu: zero-extend sh[15:0]
  - lw: mem_rdata
- Any error forces rsp_rdata=0.
- Reset mid-operation: drop to IDLE at the next edge. mem_req is 0 the cycle after rst; no response is issued for the abandoned request.

Test Plan:
- lb @0x1003, mem_rdata=0x80FF_1234, gnt and rvalid immediate -> mem_addr=0x1000, be=1111, rsp_valid at accept+3, rsp_rdata=0xFFFFFF80, err=0.
- lhu @0x2002, rdata=0xBEEF_0000 -> rsp_rdata=0x0000BEEF. Same access with lh -> 0xFFFFBEEF.
- sb @0x3001 wdata=0xAA -> be=0010, mem_wdata=0xAAAAAAAA, mem_we=1, rsp_rdata=0. sh @0x3002 wdata=0x1234 -> be=1100, wdata=0x12341234.
- Misaligned lw @0x4001, and op=011 load -> mem_req never asserts, rsp_valid at accept+1, err=1, rdata=0.
- gnt withheld 5 cycles -> mem_req and all mem_* stable throughout; TIMEOUT_CYCLES=4 with no rvalid -> err=1 after 4 WAIT cycles. A late rvalid in IDLE is ignored.
- rst asserted in WAIT -> IDLE next cycle, mem_req=0, no rsp_valid; a following lw @0x10 completes normally.
